// File: rtl/plru_state_array_pkg.sv
// Shared types, sizes and the tree-update function for the 8-way pseudo-LRU state array.
//   PLRU_SIZE / WAYS / WAY_BITS : tree and way widths
//   op_e                         : request opcode (READ, TOUCH)
//   state_e                      : sweep/run state
//   plru_touch()                 : point the tree away from an accessed way
package plru_state_array_pkg;

    localparam int unsigned PLRU_SIZE = 7;
    localparam int unsigned WAYS      = 8;
    localparam int unsigned WAY_BITS  = 3;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_TOUCH = 1'b1
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Root takes way[2]; the level-1 node on that side takes way[1]; the leaf takes way[0].
    function automatic logic [PLRU_SIZE-1:0] plru_touch(
        input logic [PLRU_SIZE-1:0] plru_in,
        input logic [WAY_BITS-1:0]  way
    );
        logic [PLRU_SIZE-1:0] plru_out;
        plru_out    = plru_in;
        plru_out[0] = way[2];
        if (!way[2]) begin
            plru_out[1] = way[1];
            if (!way[1]) plru_out[3] = way[0];
            else         plru_out[4] = way[0];
        end else begin
            plru_out[2] = way[1];
            if (!way[1]) plru_out[5] = way[0];
            else         plru_out[6] = way[0];
        end
        return plru_out;
    endfunction

endpackage

// File: rtl/plru_state_array_sram.sv
// NUM_SETS x PLRU_SIZE storage, one write port and one synchronous read port (1-cycle latency).
// A read colliding with a write to the same address returns the old contents.
//   clk                      : clock
//   i_wr_en/i_wr_addr/i_wr_data : write port
//   i_rd_en/i_rd_addr        : read request
//   o_rd_data                : read data, valid the cycle after i_rd_en
module plru_sram
    import plru_state_array_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16384
) (
    input  logic                        clk,
    input  logic                        i_wr_en,
    input  logic [$clog2(NUM_SETS)-1:0] i_wr_addr,
    input  logic [PLRU_SIZE-1:0]        i_wr_data,
    input  logic                        i_rd_en,
    input  logic [$clog2(NUM_SETS)-1:0] i_rd_addr,
    output logic [PLRU_SIZE-1:0]        o_rd_data
);

    logic [PLRU_SIZE-1:0] r_mem [NUM_SETS];

    // Storage has no reset; the owner sweeps it after reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/plru_state_array.sv
// Per-set pseudo-LRU tree storage with READ/TOUCH pipeline, bypass and flush sweep.
//   clk, rst_n        : clock, async active-low reset
//   clear_req         : one-cycle flush pulse, restarts the sweep
//   req_*             : request (op, set, way); accepted when req_valid && req_ready
//   rsp_valid/set/plru: READ response, two edges after accept
//   init_busy         : sweep in progress
module plru_state_array
    import plru_state_array_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16384
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_req,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_op,
    input  logic [$clog2(NUM_SETS)-1:0] req_set,
    input  logic [WAY_BITS-1:0]         req_way,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_SETS)-1:0] rsp_set,
    output logic [PLRU_SIZE-1:0]        rsp_plru,
    output logic                        init_busy
);

    localparam int unsigned SET_BITS = $clog2(NUM_SETS);

    state_e                r_state, w_state_nxt;
    logic [SET_BITS-1:0]   r_sweep_cnt, w_sweep_cnt_nxt;
    logic                  r_init_busy, w_init_busy_nxt;
    logic                  w_sweep_wr;

    logic                  w_accept;
    logic                  r_s1_valid;
    op_e                   r_s1_op;
    logic [SET_BITS-1:0]   r_s1_set;
    logic [WAY_BITS-1:0]   r_s1_way;
    logic [PLRU_SIZE-1:0]  w_rd_data, w_s1_cur, w_s1_res;

    logic                  r_s2_valid;
    op_e                   r_s2_op;
    logic [SET_BITS-1:0]   r_s2_set;
    logic [PLRU_SIZE-1:0]  r_s2_plru;

    logic                  w_touch_wr, w_wr_en;
    logic [SET_BITS-1:0]   w_wr_addr;
    logic [PLRU_SIZE-1:0]  w_wr_data;
    logic                  r_lw_valid;
    logic [SET_BITS-1:0]   r_lw_set;
    logic [PLRU_SIZE-1:0]  r_lw_plru;

    logic                  r_rsp_valid;
    logic [SET_BITS-1:0]   r_rsp_set;
    logic [PLRU_SIZE-1:0]  r_rsp_plru;

    // State register; init_busy is registered so it reads 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_sweep_cnt <= '0;
            r_init_busy <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_cnt <= w_sweep_cnt_nxt;
            r_init_busy <= w_init_busy_nxt;
        end
    end

    // Next state; the sweep only writes once init_busy is up, so busy lasts NUM_SETS cycles.
    always_comb begin
        w_state_nxt     = r_state;
        w_sweep_cnt_nxt = r_sweep_cnt;
        w_sweep_wr      = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (clear_req) begin
                    w_sweep_cnt_nxt = '0;
                end else if (r_init_busy) begin
                    w_sweep_wr      = 1'b1;
                    w_sweep_cnt_nxt = r_sweep_cnt + SET_BITS'(1);
                    if (r_sweep_cnt == SET_BITS'(NUM_SETS - 1)) w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    w_state_nxt     = ST_INIT;
                    w_sweep_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
        w_init_busy_nxt = (w_state_nxt == ST_INIT);
    end

    assign req_ready = (r_state == ST_RUN) && !clear_req;
    assign w_accept  = req_valid && req_ready;

    plru_sram #(.NUM_SETS(NUM_SETS)) u_sram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_accept),
        .i_rd_addr (req_set),
        .o_rd_data (w_rd_data)
    );

    // Bypass: S2 (one op older) beats the register written on this cycle's read edge.
    always_comb begin
        w_s1_cur = w_rd_data;
        if (r_lw_valid && (r_lw_set == r_s1_set)) w_s1_cur = r_lw_plru;
        if (r_s2_valid && (r_s2_op == OP_TOUCH) && (r_s2_set == r_s1_set)) w_s1_cur = r_s2_plru;
        w_s1_res = (r_s1_op == OP_TOUCH) ? plru_touch(w_s1_cur, r_s1_way) : w_s1_cur;
    end

    // In-flight TOUCH writes are dropped once a flush starts; the sweep owns the port.
    assign w_touch_wr = r_s2_valid && (r_s2_op == OP_TOUCH) && (r_state == ST_RUN) && !clear_req;
    assign w_wr_en    = w_sweep_wr || w_touch_wr;
    assign w_wr_addr  = w_sweep_wr ? r_sweep_cnt : r_s2_set;
    assign w_wr_data  = w_sweep_wr ? '0 : r_s2_plru;

    // Pipeline stages, last-write register and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= OP_READ;
            r_s1_set    <= '0;
            r_s1_way    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_op     <= OP_READ;
            r_s2_set    <= '0;
            r_s2_plru   <= '0;
            r_lw_valid  <= 1'b0;
            r_lw_set    <= '0;
            r_lw_plru   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_set   <= '0;
            r_rsp_plru  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op  <= op_e'(req_op);
                r_s1_set <= req_set;
                r_s1_way <= req_way;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_op   <= r_s1_op;
                r_s2_set  <= r_s1_set;
                r_s2_plru <= w_s1_res;
            end
            r_lw_valid <= w_touch_wr;
            if (w_touch_wr) begin
                r_lw_set  <= r_s2_set;
                r_lw_plru <= r_s2_plru;
            end
            r_rsp_valid <= r_s2_valid && (r_s2_op == OP_READ);
            if (r_s2_valid && (r_s2_op == OP_READ)) begin
                r_rsp_set  <= r_s2_set;
                r_rsp_plru <= r_s2_plru;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_set   = r_rsp_set;
    assign rsp_plru  = r_rsp_plru;
    assign init_busy = r_init_busy;

endmodule

// File: tb/tb_plru_state_array.sv
// Directed bench for plru_state_array with NUM_SETS=16 and hand-computed tree values.
module tb_plru_state_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_req;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [3:0] req_set;
    logic [2:0] req_way;
    logic       rsp_valid;
    logic [3:0] rsp_set;
    logic [6:0] rsp_plru;
    logic       init_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] set;
        logic [6:0] plru;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t e;

    plru_state_array #(.NUM_SETS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_set   (req_set),
        .req_way   (req_way),
        .rsp_valid (rsp_valid),
        .rsp_set   (rsp_set),
        .rsp_plru  (rsp_plru),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        clear_req = 1'b0;
    endtask

    // Present one request for one edge; READs register their expected response.
    task automatic send(input logic op, input int s, input int w, input logic [6:0] exp_plru);
        req_valid = 1'b1;
        req_op    = op;
        req_set   = 4'(s);
        req_way   = 3'(w);
        #1;
        check("req_ready", 32'(req_ready), 32'd1);
        tick();
        if (op == 1'b0) q.push_back('{set: 4'(s), plru: exp_plru, due: cyc + 2});
    endtask

    // Count init_busy cycles from the current sample until it drops (bounded).
    task automatic wait_init(input string tag);
        int n;
        int ov;
        n  = 0;
        ov = 0;
        for (int i = 0; i < 40; i++) begin
            if (init_busy) begin
                n++;
                if (req_ready) ov++;
            end else if (n > 0) begin
                break;
            end
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'd16);
        check({tag, "_ready_in_init"}, 32'(ov), 32'd0);
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    // Response scoreboard: order, set, value and fixed latency.
    always @(posedge clk) begin
        #1;
        if (rsp_valid) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("rsp_set", 32'(rsp_set), 32'(e.set));
                check("rsp_plru", 32'(rsp_plru), 32'(e.plru));
                check("rsp_latency", 32'(cyc), 32'(e.due));
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            check("rsp_missing", 32'(rsp_valid), 32'd1);
            void'(q.pop_front());
        end
    end

    initial begin
        rst_n     = 1'b0;
        clear_req = 1'b0;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_set   = '0;
        req_way   = '0;
        #1;
        check("rst_init_busy", 32'(init_busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_init("por");

        // Fresh set reads all-zero.
        send(1'b0, 5, 0, 7'b0000000);
        idle();
        repeat (3) tick();

        // Back-to-back on set 3: way7 then way2, then read.
        send(1'b1, 3, 7, 7'b0);
        send(1'b1, 3, 2, 7'b0);
        send(1'b0, 3, 0, 7'b1000110);
        idle();
        repeat (3) tick();

        // Interleaved sets, no cross-set forwarding.
        send(1'b1, 1, 4, 7'b0);
        send(1'b1, 2, 1, 7'b0);
        send(1'b0, 1, 0, 7'b0000001);
        send(1'b0, 2, 0, 7'b0001000);
        idle();
        repeat (3) tick();

        // Forward from the last-written register (TOUCH two edges ahead).
        send(1'b1, 6, 5, 7'b0);
        send(1'b0, 7, 0, 7'b0000000);
        send(1'b0, 6, 0, 7'b0100001);
        idle();
        repeat (3) tick();

        // Flush: clear wins over a concurrent request, in-flight TOUCH is dropped.
        send(1'b1, 4, 6, 7'b0);
        clear_req = 1'b1;
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_set   = 4'd4;
        #1;
        check("clear_blocks_ready", 32'(req_ready), 32'd0);
        tick();
        idle();
        wait_init("flush");
        send(1'b0, 4, 0, 7'b0000000);
        send(1'b0, 3, 0, 7'b0000000);
        idle();
        repeat (3) tick();

        // Async reset in the middle of a sweep.
        send(1'b1, 15, 0, 7'b0);
        idle();
        repeat (2) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (7) tick();
        check("mid_sweep_busy", 32'(init_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_init_busy", 32'(init_busy), 32'd0);
        check("async_req_ready", 32'(req_ready), 32'd0);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_init("rerst");

        // Streaming reads over every set, one TOUCHed beforehand.
        send(1'b1, 9, 3, 7'b0);
        for (int i = 0; i < 16; i++) send(1'b0, i, 0, (i == 9) ? 7'b0010010 : 7'b0000000);
        idle();
        repeat (4) tick();

        check("pending_rsp", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
